// File: rtl/sram_stream_ctrl.sv
// Drains 17-bit command/data beats from the SRAM-path FIFO into timed asynchronous SRAM
// write cycles, and serves single-word image-pipeline reads ahead of FIFO traffic.
module sram_stream_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int WR_CYCLES  = 2,
    parameter int RD_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [16:0]           fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [15:0]           rd_data,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n,
    output logic [15:0]           sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [15:0]           sram_dq_in
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] DECODE   = 3'd2;
    localparam logic [2:0] WR_PULSE = 3'd3;
    localparam logic [2:0] WR_HOLD  = 3'd4;
    localparam logic [2:0] RD_SETUP = 3'd5;
    localparam logic [2:0] RD_WAIT  = 3'd6;
    localparam logic [2:0] RD_DONE  = 3'd7;

    localparam int MAX_CYCLES = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

    logic [2:0]            state;
    logic [CNT_W-1:0]      cycleCnt;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [ADDR_WIDTH-1:0] beatAddr;

    // Address beats carry at most 16 address bits; wider SRAMs get the upper bits cleared.
    generate
        if (ADDR_WIDTH <= 16) begin : gNarrowAddr
            assign beatAddr = fifo_data[ADDR_WIDTH-1:0];
        end else begin : gWideAddr
            assign beatAddr = {{(ADDR_WIDTH-16){1'b0}}, fifo_data[15:0]};
        end
    endgenerate

    assign busy = (state != IDLE);

    // All pad controls are registered, so each state's pin values appear for the
    // whole cycle spent in that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cycleCnt    <= '0;
            wrAddr      <= '0;
            fifo_rd_en  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_ce_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        sram_addr  <= rd_addr;
                        sram_ce_n  <= 1'b0;
                        sram_dq_oe <= 1'b0;
                        state      <= RD_SETUP;
                    end else if (!fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    fifo_rd_en <= 1'b0;
                    state      <= DECODE;
                end
                DECODE: begin
                    if (fifo_data[16]) begin
                        wrAddr <= beatAddr;
                        state  <= IDLE;
                    end else begin
                        sram_addr   <= wrAddr;
                        sram_dq_out <= fifo_data[15:0];
                        sram_dq_oe  <= 1'b1;
                        sram_ce_n   <= 1'b0;
                        sram_we_n   <= 1'b0;
                        cycleCnt    <= '0;
                        state       <= WR_PULSE;
                    end
                end
                WR_PULSE: begin
                    if (cycleCnt == WR_LAST) begin
                        sram_we_n <= 1'b1;
                        cycleCnt  <= '0;
                        state     <= WR_HOLD;
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    wrAddr     <= wrAddr + ADDR_WIDTH'(1);
                    state      <= IDLE;
                end
                RD_SETUP: begin
                    sram_oe_n <= 1'b0;
                    cycleCnt  <= '0;
                    state     <= RD_WAIT;
                end
                RD_WAIT: begin
                    // Data is captured while oe_n is still low, on the final wait clock.
                    if (cycleCnt == RD_LAST) begin
                        rd_data   <= sram_dq_in;
                        sram_oe_n <= 1'b1;
                        sram_ce_n <= 1'b1;
                        rd_valid  <= 1'b1;
                        cycleCnt  <= '0;
                        state     <= RD_DONE;
                    end else begin
                        cycleCnt <= cycleCnt + CNT_W'(1);
                    end
                end
                RD_DONE: begin
                    rd_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
